glitc_intercom_rx: RTL and testbench

GLITC_INTERCOM_RX -- requirements
Module: glitc_intercom_rx

---
 rtl/glitc_intercom_rx.sv | 137 +++++++++++++
 tb/tb_glitc_intercom_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/glitc_intercom_rx.sv
`default_nettype none
// ============================================================================
// Module   : glitc_intercom_rx
// Brief    : 4-lane intercom deframer; hunts for a sync word, verifies its
//            alignment, then emits 16-bit data words while locked.
// Revision : 1.0  initial release
// ============================================================================
module glitc_intercom_rx #(
    parameter logic [15:0] SYNC_WORD  = 16'hB5A3,
    parameter int unsigned LOCK_COUNT = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  in_i,
    input  logic        disable_i,
    input  logic        realign_i,
    output logic [15:0] word_o,
    output logic        word_valid_o,
    output logic        locked_o,
    output logic [1:0]  phase_o,
    output logic [7:0]  sync_err_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] C_LOCK_COUNT = 4'(LOCK_COUNT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rst_sync;
    logic [3:0]  r_in_q;
    logic [15:0] r_sr;
    logic [1:0]  r_cnt;
    logic [3:0]  r_match;
    logic [3:0]  w_match_nxt;
    logic [7:0]  w_err_nxt;
    logic        w_cnt_load;
    logic        w_emit;
    logic        w_run;
    logic        w_boundary;
    logic        w_sync_hit;

    assign w_run      = r_rst_sync[1];
    assign w_boundary = (r_cnt == 2'd3);
    assign w_sync_hit = (r_sr == SYNC_WORD);

    // Reset release is re-timed before the FSM may leave HUNT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_err_nxt   = sync_err_o;
        w_cnt_load  = 1'b0;
        w_emit      = 1'b0;
        if (disable_i || !w_run || realign_i) begin
            w_state_nxt = HUNT;
            w_match_nxt = 4'd0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_sync_hit) begin
                        w_cnt_load  = 1'b1;
                        w_match_nxt = 4'd1;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_boundary) begin
                        if (w_sync_hit) begin
                            w_match_nxt = r_match + 4'd1;
                            if ((r_match + 4'd1) >= C_LOCK_COUNT) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_state_nxt = HUNT;
                            w_match_nxt = 4'd0;
                            if (sync_err_o != 8'hFF) begin
                                w_err_nxt = sync_err_o + 8'd1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    // Sync words seen while locked are idle fill, not data
                    w_emit = w_boundary && !w_sync_hit;
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_match_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= HUNT;
            r_in_q       <= 4'd0;
            r_sr         <= 16'd0;
            r_cnt        <= 2'd0;
            r_match      <= 4'd0;
            word_o       <= 16'd0;
            word_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            phase_o      <= 2'd0;
            sync_err_o   <= 8'd0;
        end else begin
            r_in_q       <= in_i;
            r_sr         <= {r_sr[11:0], r_in_q};
            r_cnt        <= w_cnt_load ? 2'd0 : r_cnt + 2'd1;
            r_state      <= w_state_nxt;
            r_match      <= w_match_nxt;
            locked_o     <= (w_state_nxt == LOCKED);
            word_valid_o <= w_emit;
            sync_err_o   <= w_err_nxt;
            if (w_cnt_load) begin
                phase_o <= r_cnt;
            end
            if (w_emit) begin
                word_o <= r_sr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glitc_intercom_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitc_intercom_rx
// Brief    : Directed stimulus with a queue-based scoreboard for the deframer.
// Revision : 1.0  initial release
// ============================================================================
module tb_glitc_intercom_rx;

    localparam logic [15:0] C_SYNC = 16'hB5A3;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [3:0]  in_i;
    logic        disable_i;
    logic        realign_i;
    logic [15:0] word_o;
    logic        word_valid_o;
    logic        locked_o;
    logic [1:0]  phase_o;
    logic [7:0]  sync_err_o;

    typedef struct {
        logic [15:0] w;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   base    = 0;
    logic lk;
    logic lk_any;

    glitc_intercom_rx #(
        .SYNC_WORD  (16'hB5A3),
        .LOCK_COUNT (8)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .in_i         (in_i),
        .disable_i    (disable_i),
        .realign_i    (realign_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .locked_o     (locked_o),
        .phase_o      (phase_o),
        .sync_err_o   (sync_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every valid pulse must match the oldest expected word and cycle
    always @(negedge clk) begin
        if (word_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'd0, word_valid_o}, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("word_data", {16'd0, word_o}, {16'd0, m_e.w});
                check("word_latency", cyc, m_e.c);
            end
        end
    end

    // One nibble per negedge, MSB nibble first; lk samples locked_o two
    // edges after the previous word's boundary edge.
    task automatic send_word(input logic [15:0] w, input bit exp_valid,
                             input bit realign_prev, input bit dis, output logic lk_o);
        exp_t e;
        lk_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) lk_o = locked_o;
            realign_i = realign_prev && (i == 1);
            disable_i = dis;
            in_i      = w[15-4*i -: 4];
        end
        if (exp_valid) begin
            e.w = w;
            e.c = cyc + 3;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n_i   = 1'b0;
        in_i      = 4'd0;
        disable_i = 1'b0;
        realign_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word", {16'd0, word_o}, 32'd0);
        check("rst_valid", {31'd0, word_valid_o}, 32'd0);
        check("rst_locked", {31'd0, locked_o}, 32'd0);
        check("rst_phase", {30'd0, phase_o}, 32'd0);
        check("rst_err", {24'd0, sync_err_o}, 32'd0);

        rst_n_i = 1'b1;
        base    = cyc;
        do @(negedge clk); while (((cyc - base) % 4) != 0 || (cyc - base) < 4);

        // Sync stream whose first match sees cnt==2
        for (int j = 1; j <= 9; j++) begin
            send_word(C_SYNC, 0, 0, 0, lk);
            if (j == 8) check("lock_after_7", {31'd0, lk}, 32'd0);
            if (j == 9) check("lock_after_8", {31'd0, lk}, 32'd1);
        end
        check("phase_offset2", {30'd0, phase_o}, 32'd2);
        check("err_clean", {24'd0, sync_err_o}, 32'd0);

        // Data words, idle fill and a sync pattern straddling a boundary
        send_word(16'h1234, 1, 0, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        check("word_hold", {16'd0, word_o}, 32'h1234);
        send_word(16'h0000, 1, 0, 0, lk);
        send_word(16'hFFFF, 1, 0, 0, lk);
        send_word(16'h00B5, 1, 0, 0, lk);
        send_word(16'hA300, 1, 0, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        check("still_locked", {31'd0, locked_o}, 32'd1);
        check("word_last", {16'd0, word_o}, 32'hA300);

        // Realign on a data boundary drops that word
        send_word(16'hABCD, 0, 0, 0, lk);
        send_word(C_SYNC, 0, 1, 0, lk);
        check("realign_unlock", {31'd0, lk}, 32'd0);
        for (int j = 2; j <= 9; j++) begin
            send_word(C_SYNC, 0, 0, 0, lk);
            if (j == 8) check("relock_after_7", {31'd0, lk}, 32'd0);
            if (j == 9) check("relock_after_8", {31'd0, lk}, 32'd1);
        end
        check("realign_err_kept", {24'd0, sync_err_o}, 32'd0);
        check("realign_word_kept", {16'd0, word_o}, 32'hA300);

        // Corrupt the 4th sync while verifying
        for (int j = 1; j <= 13; j++) begin
            send_word((j == 4) ? 16'hB5A2 : C_SYNC, 0, (j == 1), 0, lk);
            if (j == 1)  check("verify_realign", {31'd0, lk}, 32'd0);
            if (j == 5)  check("verify_fail_nolock", {31'd0, lk}, 32'd0);
            if (j == 12) check("verify_relock_7", {31'd0, lk}, 32'd0);
            if (j == 13) check("verify_relock_8", {31'd0, lk}, 32'd1);
        end
        check("verify_err1", {24'd0, sync_err_o}, 32'd1);

        // 300 failed verify attempts: counter saturates
        for (int p = 1; p <= 300; p++) begin
            if (p == 255) check("err_254", {24'd0, sync_err_o}, 32'd254);
            if (p == 256) check("err_255", {24'd0, sync_err_o}, 32'd255);
            send_word(C_SYNC, 0, (p == 1), 0, lk);
            send_word(16'h0000, 0, 0, 0, lk);
        end
        repeat (3) @(negedge clk);
        check("err_saturated", {24'd0, sync_err_o}, 32'd255);

        // Disable (with a coincident realign) blocks locking
        lk_any = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            send_word(C_SYNC, 0, (j == 1), 1, lk);
            lk_any = lk_any | lk | locked_o;
        end
        check("disable_no_lock", {31'd0, lk_any}, 32'd0);
        for (int j = 11; j <= 18; j++) begin
            send_word(C_SYNC, 0, 0, 0, lk);
            if (j == 17) check("resume_lock_7", {31'd0, lk}, 32'd0);
            if (j == 18) check("resume_lock_8", {31'd0, lk}, 32'd1);
        end

        // Reset asserted mid-word during VERIFY
        send_word(C_SYNC, 0, 1, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        send_word(C_SYNC, 0, 0, 0, lk);
        @(negedge clk);
        in_i = 4'hB;
        @(negedge clk);
        in_i    = 4'h5;
        rst_n_i = 1'b0;
        #1;
        check("async_word", {16'd0, word_o}, 32'd0);
        check("async_valid", {31'd0, word_valid_o}, 32'd0);
        check("async_locked", {31'd0, locked_o}, 32'd0);
        check("async_phase", {30'd0, phase_o}, 32'd0);
        check("async_err", {24'd0, sync_err_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_locked", {31'd0, locked_o}, 32'd0);
        check("pending_expect", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
